// File: rtl/ahb_to_cmd_master_pkg.sv
// AHB-Lite encodings and command legality check shared by ahb_to_cmd_master.
package ahb_to_cmd_master_pkg;

  localparam logic [1:0] AMBA_AHB_HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] AMBA_AHB_HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] AMBA_AHB_HSIZE_BYTE = 3'b000;
  localparam logic [2:0] AMBA_AHB_HSIZE_HALF = 3'b001;
  localparam logic [2:0] AMBA_AHB_HSIZE_WORD = 3'b010;

  localparam logic [2:0] AMBA_AHB_HBURST_SINGLE = 3'b000;

  // Sizes above a word, or addresses not aligned to the transfer size, never reach the bus.
  function automatic logic cmd_is_legal(input logic [2:0] size, input logic [1:0] addr_lsb);
    logic legal;
    case (size)
      AMBA_AHB_HSIZE_BYTE: legal = 1'b1;
      AMBA_AHB_HSIZE_HALF: legal = ~addr_lsb[0];
      AMBA_AHB_HSIZE_WORD: legal = (addr_lsb == 2'b00);
      default:             legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/ahb_to_cmd_master.sv
// AHB-Lite manager: valid/ready commands become NONSEQ SINGLE transfers, one response each.
// Define AHB_CMD_MASTER_PIPELINE_EN to overlap the next address phase with the current data phase.
module ahb_to_cmd_master
  import ahb_to_cmd_master_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [AW-1:0] cmd_addr,
  input  logic          cmd_write,
  input  logic [2:0]    cmd_size,
  input  logic [31:0]   cmd_wdata,
  output logic          rsp_valid,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic          busy,
  output logic [AW-1:0] HADDR,
  output logic [1:0]    HTRANS,
  output logic [2:0]    HSIZE,
  output logic          HWRITE,
  output logic [2:0]    HBURST,
  output logic [31:0]   HWDATA,
  input  logic [31:0]   HRDATA,
  input  logic          HREADY,
  input  logic          HRESP
);

  logic          a_valid_q, a_valid_d;
  logic [AW-1:0] a_addr_q, a_addr_d;
  logic [2:0]    a_size_q, a_size_d;
  logic          a_write_q, a_write_d;
  logic [31:0]   a_wdata_q, a_wdata_d;
  logic          d_valid_q, d_valid_d;
  logic          d_write_q, d_write_d;
  logic [31:0]   d_wdata_q, d_wdata_d;
  logic          err_hold_q, err_hold_d;
  logic [1:0]    htrans_q, htrans_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;

  logic cmd_legal, cmd_ready_c, busy_c, a_adv, d_done, cmd_fire;

  always_comb begin
    cmd_legal = cmd_is_legal(cmd_size, cmd_addr[1:0]);
    a_adv     = a_valid_q & HREADY & ~err_hold_q & ~HRESP;
    d_done    = d_valid_q & HREADY;
    busy_c    = a_valid_q | d_valid_q | rsp_valid_q;
`ifdef AHB_CMD_MASTER_PIPELINE_EN
    // Illegal commands wait for an empty pipe so their response cannot collide with a bus response.
    cmd_ready_c = (~a_valid_q | a_adv) & (cmd_legal | (~a_valid_q & ~d_valid_q));
`else
    cmd_ready_c = ~busy_c;
`endif
    cmd_fire = cmd_valid & cmd_ready_c;
  end

  always_comb begin
    a_valid_d = a_valid_q;
    a_addr_d  = a_addr_q;
    a_size_d  = a_size_q;
    a_write_d = a_write_q;
    a_wdata_d = a_wdata_q;
    d_valid_d = d_valid_q;
    d_write_d = d_write_q;
    d_wdata_d = d_wdata_q;
    err_hold_d  = err_hold_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;

    if (a_adv) a_valid_d = 1'b0;
    if (cmd_fire & cmd_legal) begin
      a_valid_d = 1'b1;
      a_addr_d  = cmd_addr;
      a_size_d  = cmd_size;
      a_write_d = cmd_write;
      a_wdata_d = cmd_wdata;
    end

    if (d_done) d_valid_d = 1'b0;
    if (a_adv) begin
      d_valid_d = 1'b1;
      d_write_d = a_write_q;
      d_wdata_d = a_wdata_q;
    end

    // First ERROR cycle cancels the pending address phase until the error completes.
    if (d_valid_q & HRESP & ~HREADY) err_hold_d = 1'b1;
    else if (d_done)                 err_hold_d = 1'b0;

    htrans_d = (a_valid_d & ~err_hold_d) ? AMBA_AHB_HTRANS_NONSEQ : AMBA_AHB_HTRANS_IDLE;

    if (d_done) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = HRESP;
      if (~d_write_q & ~HRESP) rsp_rdata_d = HRDATA;
    end else if (cmd_fire & ~cmd_legal) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = 1'b1;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      a_valid_q   <= 1'b0;
      a_addr_q    <= '0;
      a_size_q    <= AMBA_AHB_HSIZE_BYTE;
      a_write_q   <= 1'b0;
      a_wdata_q   <= '0;
      d_valid_q   <= 1'b0;
      d_write_q   <= 1'b0;
      d_wdata_q   <= '0;
      err_hold_q  <= 1'b0;
      htrans_q    <= AMBA_AHB_HTRANS_IDLE;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      a_valid_q   <= a_valid_d;
      a_addr_q    <= a_addr_d;
      a_size_q    <= a_size_d;
      a_write_q   <= a_write_d;
      a_wdata_q   <= a_wdata_d;
      d_valid_q   <= d_valid_d;
      d_write_q   <= d_write_d;
      d_wdata_q   <= d_wdata_d;
      err_hold_q  <= err_hold_d;
      htrans_q    <= htrans_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cmd_ready = cmd_ready_c;
  assign busy      = busy_c;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign HADDR     = a_addr_q;
  assign HTRANS    = htrans_q;
  assign HSIZE     = a_size_q;
  assign HWRITE    = a_write_q;
  assign HBURST    = AMBA_AHB_HBURST_SINGLE;
  assign HWDATA    = d_wdata_q;

endmodule
